knn_seq_ctrl: RTL and testbench
===============================

KNN_SEQ_CTRL -- requirements
Module: knn_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ATTR, default 4, number of attributes per sample (1..255).
REQ-002 SHALL have parameter GAP, default 2, idle cycles after each pronto pulse (0..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, maximum cycles waiting for a result (16-bit).
REQ-004 SHALL have port clk50_0_clk  in  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port reset_clk50_0_reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port host_wr_en  in  1  write host_wr_data into sample buffer entry host_wr_addr.
REQ-007 SHALL have port host_wr_addr  in  8  attribute index.
REQ-008 SHALL have port host_wr_data  in  16  attribute value.
REQ-009 SHALL have port host_start  in  1  one-cycle pulse, start a transfer.
REQ-010 SHALL have port host_train  in  1  mode sampled with host_start: 1 training, 0 classification.
REQ-011 SHALL have port host_knn_rst  in  1  one-cycle pulse requesting a KNN core reset.
REQ-012 SHALL have ports host_busy out 1, host_done out 1 (one-cycle pulse), host_timeout out 1 (sticky until next start), host_classe out 16 (last result).
REQ-013 SHALL have ports knn_dados_atributo_out out 8, knn_dados_valor_out out 16, knn_dados_pronto_out out 1, knn_treinamento_out out 1, knn_reset_out out 1 (active-high).
REQ-014 SHALL have ports knn_classe_prevista_in in 16, knn_classe_prevista_pronto_in in 1.

Function
REQ-015 SHALL hold an N_ATTR x 16-bit sample buffer; writes with host_wr_addr >= N_ATTR or while host_busy=1 SHALL be ignored.
REQ-016 SHALL implement states IDLE, SEND, GAP, WAIT_RES, DONE, KRST.
REQ-017 IDLE: host_start -> SEND with index 0, mode latched into knn_treinamento_out, host_timeout cleared; host_busy=1 from the next cycle.
REQ-018 SEND: knn_dados_pronto_out=1 for exactly one cycle, atributo=index, valor=buffer[index]; atributo/valor SHALL remain stable through the following GAP cycles.
REQ-019 SEND -> GAP for GAP cycles (GAP=0 skips it); then index<N_ATTR-1 -> SEND with index+1, else training -> DONE, classification -> WAIT_RES.
REQ-020 First pronto SHALL occur the cycle after host_start; full transfer SHALL take N_ATTR*(1+GAP) cycles.
REQ-021 WAIT_RES: knn_classe_prevista_pronto_in=1 SHALL capture knn_classe_prevista_in into host_classe, -> DONE.
REQ-022 knn_classe_prevista_pronto_in outside WAIT_RES SHALL be ignored; host_classe unchanged.
REQ-023 DONE: host_done=1 for one cycle, host_busy=0 in the same cycle, -> IDLE.
REQ-024 host_start while busy SHALL be ignored.
REQ-025 host_knn_rst in any state SHALL abort, -> KRST: knn_reset_out=1 for 4 cycles, pronto=0, no host_done, then IDLE; host_knn_rst wins over a simultaneous host_start.
REQ-026 knn_dados_pronto_out SHALL be 0 in every state except SEND.

Reset
REQ-027 On reset_clk50_0_reset_n=0: state IDLE, index 0, all outputs 0 including host_classe, host_timeout, knn_reset_out; buffer contents cleared to 0.
REQ-028 Reset deassertion mid-transfer SHALL resume from IDLE with no pronto pulse until a new host_start.

Configuration
REQ-029 With KNN_SEQ_TIMEOUT_EN defined: a counter runs in WAIT_RES; after TIMEOUT_CYC cycles without a result, host_timeout=1, host_classe unchanged, -> DONE; result arriving in the expiry cycle SHALL win (no timeout).
REQ-030 Without KNN_SEQ_TIMEOUT_EN: WAIT_RES waits indefinitely, host_timeout tied 0, no counter logic.

Verification
REQ-031 N_ATTR=4, GAP=2, buffer {0x0010,0x0020,0x0030,0x0040}, start train=1 -> pronto at cycles 1,4,7,10 with atributo 0..3, host_done at cycle 13, no result wait.
REQ-032 Same buffer, train=0, classe_pronto with 0x0005 at cycle 20 -> host_classe=0x0005, host_done cycle 21.
REQ-033 KNN_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, no result -> host_timeout=1, host_done exactly 100 cycles after WAIT_RES entry; classe_pronto in expiry cycle -> host_timeout=0.
REQ-034 host_knn_rst during SEND of index 2 -> knn_reset_out high 4 cycles, no further pronto, no host_done; host_start during busy and write to addr 7 -> no effect.
REQ-035 Assert reset during GAP -> all outputs 0 asynchronously; after release, no pronto until host_start.

Source files
------------

// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl: streams a buffered sample to a KNN core attribute by attribute and collects the class.
// Define KNN_SEQ_TIMEOUT_EN to bound the wait for a result to TIMEOUT_CYC cycles.

module knn_seq_ctrl #(
  parameter int N_ATTR      = 4,
  parameter int GAP         = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk50_0_clk,
  input  logic        reset_clk50_0_reset_n,
  input  logic        host_wr_en,
  input  logic [7:0]  host_wr_addr,
  input  logic [15:0] host_wr_data,
  input  logic        host_start,
  input  logic        host_train,
  input  logic        host_knn_rst,
  output logic        host_busy,
  output logic        host_done,
  output logic        host_timeout,
  output logic [15:0] host_classe,
  output logic [7:0]  knn_dados_atributo_out,
  output logic [15:0] knn_dados_valor_out,
  output logic        knn_dados_pronto_out,
  output logic        knn_treinamento_out,
  output logic        knn_reset_out,
  input  logic [15:0] knn_classe_prevista_in,
  input  logic        knn_classe_prevista_pronto_in
);
  // state    | meaning
  // IDLE     | waiting for host_start, buffer writable
  // SEND     | one-cycle pronto for attribute r_idx
  // GAP      | idle spacing after each pronto, attribute/value held
  // WAIT_RES | classification sent, waiting for the core's class
  // DONE     | one-cycle host_done
  // KRST     | four-cycle reset pulse to the core

  localparam int         IW       = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  localparam logic [8:0] N_ATTR_L = 9'(N_ATTR);
  localparam logic [7:0] LAST_IDX = 8'(N_ATTR - 1);
  localparam logic [3:0] GAP_L    = 4'(GAP);

  if (N_ATTR < 1 || N_ATTR > 255 || GAP < 0 || GAP > 15 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("knn_seq_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_WAIT_RES, S_DONE, S_KRST
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_after;
  logic [7:0]  r_idx;
  logic [3:0]  r_gap_cnt;
  logic [1:0]  r_krst_cnt;
  logic        r_train;
  logic [15:0] r_classe;
  logic [15:0] r_buf [N_ATTR];
  logic        w_busy;
  logic        w_capture;
  logic        w_start;

`ifdef KNN_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_L = 16'(TIMEOUT_CYC);
  logic [15:0] r_to_cnt;
  logic        r_timeout;
  logic        w_expire;
`endif

  assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_start = (r_state == S_IDLE) && (w_next == S_SEND);
  assign w_after = (r_idx != LAST_IDX) ? S_SEND : (r_train ? S_DONE : S_WAIT_RES);

  always_ff @(posedge clk50_0_clk or negedge reset_clk50_0_reset_n) begin
    if (!reset_clk50_0_reset_n) r_state <= S_IDLE;
    else                        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
`ifdef KNN_SEQ_TIMEOUT_EN
    w_expire  = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (host_start) w_next = S_SEND;
      S_SEND:   w_next = (GAP_L != 4'd0) ? S_GAP : w_after;
      S_GAP:    if (r_gap_cnt == 4'd0) w_next = w_after;
      S_WAIT_RES: begin
        // a result in the expiry cycle takes priority over the timeout
        if (knn_classe_prevista_pronto_in) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
`ifdef KNN_SEQ_TIMEOUT_EN
        else if (r_to_cnt == 16'd0) begin
          w_expire = 1'b1;
          w_next   = S_DONE;
        end
`endif
      end
      S_DONE:   w_next = S_IDLE;
      S_KRST:   if (r_krst_cnt == 2'd0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (host_knn_rst) begin
      w_next    = S_KRST;
      w_capture = 1'b0;
`ifdef KNN_SEQ_TIMEOUT_EN
      w_expire  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk50_0_clk or negedge reset_clk50_0_reset_n) begin
    if (!reset_clk50_0_reset_n) begin
      r_idx      <= 8'd0;
      r_gap_cnt  <= 4'd0;
      r_krst_cnt <= 2'd0;
      r_train    <= 1'b0;
      r_classe   <= 16'd0;
    end else begin
      if (w_start) begin
        r_idx   <= 8'd0;
        r_train <= host_train;
      end else if (w_next == S_SEND) begin
        r_idx <= r_idx + 8'd1;
      end
      if (r_state == S_SEND)     r_gap_cnt <= GAP_L - 4'd1;
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 4'd1;
      if (host_knn_rst)           r_krst_cnt <= 2'd3;
      else if (r_state == S_KRST) r_krst_cnt <= r_krst_cnt - 2'd1;
      if (w_capture) r_classe <= knn_classe_prevista_in;
    end
  end

`ifdef KNN_SEQ_TIMEOUT_EN
  always_ff @(posedge clk50_0_clk or negedge reset_clk50_0_reset_n) begin
    if (!reset_clk50_0_reset_n) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start)       r_timeout <= 1'b0;
      else if (w_expire) r_timeout <= 1'b1;
      if (w_next == S_WAIT_RES && r_state != S_WAIT_RES) r_to_cnt <= TO_L - 16'd1;
      else if (r_state == S_WAIT_RES)                    r_to_cnt <= r_to_cnt - 16'd1;
    end
  end
  assign host_timeout = r_timeout;
`else
  assign host_timeout = 1'b0;
`endif

  // the buffer is frozen while busy, so the value output stays stable through GAP
  always_ff @(posedge clk50_0_clk or negedge reset_clk50_0_reset_n) begin
    if (!reset_clk50_0_reset_n) begin
      for (int i = 0; i < N_ATTR; i++) r_buf[i] <= 16'd0;
    end else if (host_wr_en && !w_busy && ({1'b0, host_wr_addr} < N_ATTR_L)) begin
      r_buf[host_wr_addr[IW-1:0]] <= host_wr_data;
    end
  end

  assign host_busy              = w_busy;
  assign host_done              = (r_state == S_DONE);
  assign host_classe            = r_classe;
  assign knn_dados_atributo_out = r_idx;
  assign knn_dados_valor_out    = r_buf[r_idx[IW-1:0]];
  assign knn_dados_pronto_out   = (r_state == S_SEND);
  assign knn_treinamento_out    = r_train;
  assign knn_reset_out          = (r_state == S_KRST);

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb_knn_seq_ctrl: randomized self-checking bench for knn_seq_ctrl against a cycle-schedule model.
// Timeout scenarios are compiled in when KNN_SEQ_TIMEOUT_EN is defined.

module tb_knn_seq_ctrl;
  localparam int NA = 4;
  localparam int G  = 2;
`ifdef KNN_SEQ_TIMEOUT_EN
  localparam int TB_TO = 100;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 65535;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [7:0]  host_wr_addr = '0;
  logic [15:0] host_wr_data = '0;
  logic        host_start = 1'b0;
  logic        host_train = 1'b0;
  logic        host_knn_rst = 1'b0;
  logic        host_busy, host_done, host_timeout;
  logic [15:0] host_classe;
  logic [7:0]  knn_dados_atributo_out;
  logic [15:0] knn_dados_valor_out;
  logic        knn_dados_pronto_out, knn_treinamento_out, knn_reset_out;
  logic [15:0] knn_classe_prevista_in = '0;
  logic        knn_classe_prevista_pronto_in = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_buf [NA];
  logic [15:0] m_classe = '0;

  always #5 clk = ~clk;

  knn_seq_ctrl #(.N_ATTR(NA), .GAP(G), .TIMEOUT_CYC(TB_TO)) dut (
    .clk50_0_clk(clk),
    .reset_clk50_0_reset_n(rst_n),
    .host_wr_en(host_wr_en),
    .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .host_start(host_start),
    .host_train(host_train),
    .host_knn_rst(host_knn_rst),
    .host_busy(host_busy),
    .host_done(host_done),
    .host_timeout(host_timeout),
    .host_classe(host_classe),
    .knn_dados_atributo_out(knn_dados_atributo_out),
    .knn_dados_valor_out(knn_dados_valor_out),
    .knn_dados_pronto_out(knn_dados_pronto_out),
    .knn_treinamento_out(knn_treinamento_out),
    .knn_reset_out(knn_reset_out),
    .knn_classe_prevista_in(knn_classe_prevista_in),
    .knn_classe_prevista_pronto_in(knn_classe_prevista_pronto_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
    if (a < NA) m_buf[a[1:0]] = d;
  endtask

  // Model: pronto every (1+G) cycles starting at cycle 1, WAIT_RES entered at NA*(1+G)+1.
  task automatic run_xfer(input bit train, input int res_delay, input logic [15:0] res_val,
                          input bit poke);
    int per, tot, e, done_c, k;
    logic [15:0] prev_classe, exp_classe;
    bit exp_to, exp_p, exp_to_now;
    per = 1 + G; tot = NA * per; e = tot + 1;
    prev_classe = m_classe; exp_classe = m_classe; exp_to = 1'b0;
    if (train) done_c = e;
    else if (res_delay >= 0 && (!TO_EN || res_delay < TB_TO)) begin
      done_c = e + res_delay + 1; exp_classe = res_val;
    end else begin
      done_c = e + TB_TO; exp_to = 1'b1;
    end
    host_train = train; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int c = 1; c <= done_c + 1; c++) begin
      host_start   = poke && (c == 3);
      host_wr_en   = poke && (c == 5);
      host_wr_addr = 8'd1; host_wr_data = 16'hDEAD;
      knn_classe_prevista_pronto_in = (!train && res_delay >= 0 && c == e + res_delay) ||
                                      (poke && c == 2);
      knn_classe_prevista_in = (poke && c == 2) ? 16'hBEEF : res_val;
      exp_p = (c <= tot) && ((c - 1) % per == 0);
      exp_to_now = (c >= done_c) ? exp_to : 1'b0;
      n_checks++;
      if (knn_dados_pronto_out !== exp_p) begin
        n_fail++; $display("FAIL pronto c=%0d got=%0b exp=%0b", c, knn_dados_pronto_out, exp_p);
      end
      if (c <= tot) begin
        k = (c - 1) / per;
        n_checks++;
        if (knn_dados_atributo_out !== 8'(k) || knn_dados_valor_out !== m_buf[k]) begin
          n_fail++;
          $display("FAIL attr_val c=%0d got=%0h/%0h exp=%0h/%0h", c, knn_dados_atributo_out,
                   knn_dados_valor_out, k, m_buf[k]);
        end
      end
      n_checks++;
      if (host_busy !== (c < done_c) || host_done !== (c == done_c)) begin
        n_fail++;
        $display("FAIL busy_done c=%0d got=%0b%0b exp=%0b%0b", c, host_busy, host_done,
                 (c < done_c), (c == done_c));
      end
      n_checks++;
      if (host_classe !== ((c >= done_c) ? exp_classe : prev_classe)) begin
        n_fail++;
        $display("FAIL classe c=%0d got=%0h exp=%0h", c, host_classe,
                 (c >= done_c) ? exp_classe : prev_classe);
      end
      n_checks++;
      if (host_timeout !== exp_to_now || knn_treinamento_out !== train || knn_reset_out !== 1'b0) begin
        n_fail++;
        $display("FAIL to_mode c=%0d got=%0b%0b%0b exp=%0b%0b0", c, host_timeout,
                 knn_treinamento_out, knn_reset_out, exp_to_now, train);
      end
      tick();
    end
    host_start = 1'b0; host_wr_en = 1'b0; knn_classe_prevista_pronto_in = 1'b0;
    m_classe = exp_classe;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({knn_dados_atributo_out, knn_dados_valor_out, knn_dados_pronto_out, knn_treinamento_out,
         knn_reset_out, host_busy, host_done, host_timeout, host_classe} !== 46'd0) begin
      n_fail++; $display("FAIL reset_outputs got busy=%0b classe=%0h", host_busy, host_classe);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NA; i++) m_buf[i] = 16'd0;
    m_classe = 16'd0;
  endtask

  task automatic test_train_vector();
    wr(8'd0, 16'h0010); wr(8'd1, 16'h0020); wr(8'd2, 16'h0030); wr(8'd3, 16'h0040);
    wr(8'd7, 16'hFFFF);
    run_xfer(1'b1, 0, 16'h0000, 1'b1);
  endtask

  task automatic test_classify_vector();
    run_xfer(1'b0, 7, 16'h0005, 1'b1);
    n_checks++;
    if (host_classe !== 16'h0005) begin
      n_fail++; $display("FAIL classify_result got=%0h exp=0005", host_classe);
    end
  endtask

  task automatic test_knn_rst();
    int per;
    bit exp_p, exp_r;
    per = 1 + G;
    host_train = 1'b1; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      host_knn_rst = (c == 7);
      host_start   = (c == 9);
      exp_p = (c <= 7) && ((c - 1) % per == 0);
      exp_r = (c >= 8) && (c <= 11);
      n_checks++;
      if (knn_dados_pronto_out !== exp_p || knn_reset_out !== exp_r ||
          host_busy !== (c <= 11) || host_done !== 1'b0) begin
        n_fail++;
        $display("FAIL krst_abort c=%0d got=%0b%0b%0b%0b exp=%0b%0b%0b0", c, knn_dados_pronto_out,
                 knn_reset_out, host_busy, host_done, exp_p, exp_r, (c <= 11));
      end
      tick();
    end
    host_knn_rst = 1'b1; host_start = 1'b1; host_train = 1'b0;
    tick();
    host_knn_rst = 1'b0; host_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (knn_dados_pronto_out !== 1'b0 || knn_reset_out !== (c <= 4) || host_done !== 1'b0) begin
        n_fail++;
        $display("FAIL krst_wins c=%0d got=%0b%0b%0b exp=0%0b0", c, knn_dados_pronto_out,
                 knn_reset_out, host_done, (c <= 4));
      end
      tick();
    end
    n_checks++;
    if (host_classe !== m_classe) begin
      n_fail++; $display("FAIL krst_classe got=%0h exp=%0h", host_classe, m_classe);
    end
  endtask

  task automatic test_async_reset();
    host_train = 1'b0; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({knn_dados_atributo_out, knn_dados_valor_out, knn_dados_pronto_out, knn_treinamento_out,
         knn_reset_out, host_busy, host_done, host_timeout, host_classe} !== 46'd0) begin
      n_fail++; $display("FAIL async_reset got busy=%0b classe=%0h", host_busy, host_classe);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < NA; i++) m_buf[i] = 16'd0;
    m_classe = 16'd0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (knn_dados_pronto_out !== 1'b0 || host_busy !== 1'b0 || host_done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset c=%0d got=%0b%0b%0b exp=000", c, knn_dados_pronto_out,
                 host_busy, host_done);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef KNN_SEQ_TIMEOUT_EN
    run_xfer(1'b0, -1, 16'h1234, 1'b0);
    run_xfer(1'b0, TB_TO, 16'h4321, 1'b0);
    run_xfer(1'b0, TB_TO - 1, 16'h0777, 1'b0);
`else
    run_xfer(1'b0, 40, 16'h0ABC, 1'b0);
`endif
  endtask

  task automatic test_random();
    int nw;
    for (int it = 0; it < 6; it++) begin
      nw = $urandom_range(2, 6);
      for (int j = 0; j < nw; j++) wr(8'($urandom_range(0, 7)), 16'($urandom));
      run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 12), 16'($urandom), it[0]);
    end
  endtask

  initial begin
    test_reset();
    test_train_vector();
    test_classify_vector();
    test_knn_rst();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
